// File: rtl/irq_arbiter.sv
// irq_arbiter: round-robin arbiter funnelling four MSI-X requesters into a single irq_proc channel
// Ports:
//   clk                      single clock
//   rst                      synchronous, active-low reset
//   req_valid/req_ready      per-requester handshake, one pending slot per requester
//   req_addr/req_data        per-requester MSI-X address (64b) and data (32b), flattened
//   irq_valid/irq_ready      granted request towards irq_proc
//   irq_func                 granted requester index, zero-extended to 4 bits
//   irq_addr/irq_data        granted address/data, held from the pending slot
//   timeout_pulse/timeout_id one-cycle abort indication and aborted index
// Optional: define IRQ_ARB_TIMEOUT_EN to abort a grant after TIMEOUT_CYCLES without irq_ready.
module irq_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*64-1:0]  req_addr,
    input  logic [NUM_REQ*32-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   irq_valid,
    output logic [3:0]             irq_func,
    output logic [63:0]            irq_addr,
    output logic [31:0]            irq_data,
    input  logic                   irq_ready,
    output logic                   timeout_pulse,
    output logic [1:0]             timeout_id
);
    localparam int IW = 2;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t              state, state_nxt;
    logic [NUM_REQ-1:0]  pending, accept, clr;
    logic [63:0]         slot_addr [NUM_REQ];
    logic [31:0]         slot_data [NUM_REQ];
    logic [IW-1:0]       rr_ptr, grant, pick;
    logic                any_pending, load, hs, abort, done;

    if (NUM_REQ != 4 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("irq_arbiter: NUM_REQ must be 4 and TIMEOUT_CYCLES at least 1");
    end

    assign accept      = req_valid & ~pending;
    assign any_pending = |pending;
    assign load        = state == IDLE && any_pending;
    assign hs          = state == ISSUE && irq_ready;
    assign done        = hs || abort;
    assign clr         = done ? NUM_REQ'(1) << grant : '0;

    // Scan from the farthest offset back to rr_ptr so the nearest pending index wins.
    always_comb begin
        pick = rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (pending[rr_ptr + IW'(k)]) pick = rr_ptr + IW'(k);
    end

    always_ff @(posedge clk)
        if (!rst) state <= IDLE;
        else      state <= state_nxt;

    always_comb
        state_nxt = state == IDLE ? (any_pending ? ISSUE : IDLE) : (done ? IDLE : ISSUE);

    always_comb begin
        irq_valid = state == ISSUE;
        irq_func  = {2'b00, grant};
        req_ready = ~pending;
    end

    // A granted slot stays pending until handshake/abort, so accept and clr never overlap.
    always_ff @(posedge clk)
        if (!rst) begin
            pending  <= '0;
            rr_ptr   <= '0;
            grant    <= '0;
            irq_addr <= '0;
            irq_data <= '0;
        end else begin
            pending <= (pending | accept) & ~clr;
            if (done) rr_ptr <= grant + IW'(1);
            if (load) begin
                grant    <= pick;
                irq_addr <= slot_addr[pick];
                irq_data <= slot_data[pick];
            end
        end

    always_ff @(posedge clk)
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_addr[i] <= '0;
                slot_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (accept[i]) begin
                    slot_addr[i] <= req_addr[i*64 +: 64];
                    slot_data[i] <= req_data[i*32 +: 32];
                end
        end

`ifdef IRQ_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tcnt;

    // tcnt holds 0 in IDLE, so it starts at 0 on every ISSUE entry.
    assign abort = state == ISSUE && !irq_ready && tcnt == TW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk)
        if (!rst) begin
            tcnt          <= '0;
            timeout_pulse <= 1'b0;
            timeout_id    <= '0;
        end else begin
            tcnt          <= state == IDLE ? '0 : (irq_ready ? tcnt : tcnt + TW'(1));
            timeout_pulse <= abort;
            if (abort) timeout_id <= grant;
        end
`else
    assign abort         = 1'b0;
    assign timeout_pulse = 1'b0;
    assign timeout_id    = '0;
`endif
endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: directed self-checking bench for irq_arbiter
module tb_irq_arbiter;
    localparam int TO = 16;
`ifdef IRQ_ARB_TIMEOUT_EN
    localparam int BP = 12;
`else
    localparam int BP = 20;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [255:0] req_addr = '0;
    logic [127:0] req_data = '0;
    logic [3:0]   req_ready;
    logic         irq_valid;
    logic [3:0]   irq_func;
    logic [63:0]  irq_addr;
    logic [31:0]  irq_data;
    logic         irq_ready = 1'b0;
    logic         timeout_pulse;
    logic [1:0]   timeout_id;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    irq_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
        .irq_valid(irq_valid), .irq_func(irq_func), .irq_addr(irq_addr), .irq_data(irq_data),
        .irq_ready(irq_ready), .timeout_pulse(timeout_pulse), .timeout_id(timeout_id)
    );

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [63:0] a, input logic [31:0] d);
        req_addr[i*64 +: 64] = a;
        req_data[i*32 +: 32] = d;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        req_valid = '0;
        irq_ready = 1'b0;
        req_addr = '0;
        req_data = '0;
        tick;
        tick;
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        req_valid = '0;
        irq_ready = 1'b0;
        tick;
        tick;
        checks++;
        if ({irq_valid, irq_func, irq_addr, irq_data, timeout_pulse, timeout_id} !== 104'd0) begin
            failures++;
            $display("FAIL reset_outputs got valid=%b func=%h addr=%h data=%h tp=%b tid=%h want all zero",
                     irq_valid, irq_func, irq_addr, irq_data, timeout_pulse, timeout_id);
        end
        rst = 1'b1;
        tick;
        checks++;
        if ({irq_valid, req_ready} !== {1'b0, 4'hF}) begin
            failures++;
            $display("FAIL reset_release got valid=%b ready=%h want valid=0 ready=f", irq_valid, req_ready);
        end
    endtask

    task automatic test_single;
        do_reset;
        irq_ready = 1'b1;
        set_req(2, 64'h0000_0000_FEE0_0000, 32'h0000_0042);
        req_valid = 4'b0100;
        tick;
        req_valid = '0;
        checks++;
        if ({irq_valid, req_ready} !== {1'b0, 4'b1011}) begin
            failures++;
            $display("FAIL single_n1 got valid=%b ready=%b want valid=0 ready=1011", irq_valid, req_ready);
        end
        tick;
        checks++;
        if ({irq_valid, irq_func, irq_addr, irq_data} !== {1'b1, 4'd2, 64'h0000_0000_FEE0_0000, 32'h0000_0042}) begin
            failures++;
            $display("FAIL single_n2 got valid=%b func=%0d addr=%h data=%h want 1/2/fee00000/42",
                     irq_valid, irq_func, irq_addr, irq_data);
        end
        tick;
        checks++;
        if ({irq_valid, req_ready} !== {1'b0, 4'hF}) begin
            failures++;
            $display("FAIL single_after got valid=%b ready=%h want valid=0 ready=f", irq_valid, req_ready);
        end
    endtask

    task automatic test_fairness;
        do_reset;
        irq_ready = 1'b1;
        for (int k = 0; k < 4; k++) set_req(k, 64'hFEE0_0000 + 64'(k * 256), 32'hA0 + 32'(k));
        req_valid = 4'hF;
        tick;
        req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            tick;
            checks++;
            if ({irq_valid, irq_func, irq_addr, irq_data} !== {1'b1, 4'(k), 64'hFEE0_0000 + 64'(k * 256), 32'hA0 + 32'(k)}) begin
                failures++;
                $display("FAIL fair_grant%0d got valid=%b func=%0d addr=%h data=%h want func=%0d",
                         k, irq_valid, irq_func, irq_addr, irq_data, k);
            end
            tick;
            checks++;
            if (irq_valid !== 1'b0) begin
                failures++;
                $display("FAIL fair_idle%0d got valid=%b want 0", k, irq_valid);
            end
        end
        tick;
        checks++;
        if ({irq_valid, req_ready} !== {1'b0, 4'hF}) begin
            failures++;
            $display("FAIL fair_done got valid=%b ready=%h want 0/f", irq_valid, req_ready);
        end
    endtask

    task automatic test_backpressure;
        do_reset;
        set_req(1, 64'h0000_0000_FEE0_1000, 32'h0000_0011);
        req_valid = 4'b0010;
        tick;
        req_valid = '0;
        tick;
        for (int c = 0; c <= BP; c++) begin
            checks++;
            if ({irq_valid, irq_func, irq_addr, irq_data, timeout_pulse} !== {1'b1, 4'd1, 64'h0000_0000_FEE0_1000, 32'h0000_0011, 1'b0}) begin
                failures++;
                $display("FAIL bp_hold%0d got valid=%b func=%0d addr=%h data=%h tp=%b want 1/1/fee01000/11/0",
                         c, irq_valid, irq_func, irq_addr, irq_data, timeout_pulse);
            end
            if (c == 5) begin
                set_req(3, 64'h0000_0000_FEE0_3000, 32'h0000_0033);
                req_valid = 4'b1000;
            end
            if (c == 6) req_valid = '0;
            if (c == BP) irq_ready = 1'b1;
            tick;
        end
        checks++;
        if ({irq_valid, req_ready} !== {1'b0, 4'b0111}) begin
            failures++;
            $display("FAIL bp_release got valid=%b ready=%b want 0/0111", irq_valid, req_ready);
        end
        tick;
        checks++;
        if ({irq_valid, irq_func, irq_data} !== {1'b1, 4'd3, 32'h0000_0033}) begin
            failures++;
            $display("FAIL bp_next got valid=%b func=%0d data=%h want 1/3/33", irq_valid, irq_func, irq_data);
        end
        tick;
        tick;
        checks++;
        if ({irq_valid, req_ready} !== {1'b0, 4'hF}) begin
            failures++;
            $display("FAIL bp_quiet got valid=%b ready=%h want 0/f", irq_valid, req_ready);
        end
    endtask

    task automatic test_rerequest;
        do_reset;
        set_req(3, 64'h0000_0000_FEE0_3000, 32'hD1);
        req_valid = 4'b1000;
        tick;
        checks++;
        if ({irq_valid, req_ready} !== {1'b0, 4'b0111}) begin
            failures++;
            $display("FAIL rr_accept got valid=%b ready=%b want 0/0111", irq_valid, req_ready);
        end
        set_req(3, 64'h0000_0000_FEE0_3100, 32'hD2);
        tick;
        checks++;
        if ({irq_valid, irq_func, irq_data} !== {1'b1, 4'd3, 32'hD1}) begin
            failures++;
            $display("FAIL rr_grant3 got valid=%b func=%0d data=%h want 1/3/d1", irq_valid, irq_func, irq_data);
        end
        set_req(0, 64'h0000_0000_FEE0_0100, 32'hD0);
        req_valid = 4'b1001;
        tick;
        req_valid = 4'b1000;
        checks++;
        if ({irq_valid, irq_func, irq_data, req_ready} !== {1'b1, 4'd3, 32'hD1, 4'b0110}) begin
            failures++;
            $display("FAIL rr_hold got valid=%b func=%0d data=%h ready=%b want 1/3/d1/0110",
                     irq_valid, irq_func, irq_data, req_ready);
        end
        tick;
        irq_ready = 1'b1;
        tick;
        checks++;
        if ({irq_valid, req_ready} !== {1'b0, 4'b1110}) begin
            failures++;
            $display("FAIL rr_cleared got valid=%b ready=%b want 0/1110", irq_valid, req_ready);
        end
        tick;
        req_valid = '0;
        checks++;
        if ({irq_valid, irq_func, irq_data, req_ready} !== {1'b1, 4'd0, 32'hD0, 4'b0110}) begin
            failures++;
            $display("FAIL rr_wrap0 got valid=%b func=%0d data=%h ready=%b want 1/0/d0/0110",
                     irq_valid, irq_func, irq_data, req_ready);
        end
        tick;
        checks++;
        if ({irq_valid, req_ready} !== {1'b0, 4'b0111}) begin
            failures++;
            $display("FAIL rr_gap got valid=%b ready=%b want 0/0111", irq_valid, req_ready);
        end
        tick;
        checks++;
        if ({irq_valid, irq_func, irq_addr, irq_data} !== {1'b1, 4'd3, 64'h0000_0000_FEE0_3100, 32'hD2}) begin
            failures++;
            $display("FAIL rr_second got valid=%b func=%0d addr=%h data=%h want 1/3/fee03100/d2",
                     irq_valid, irq_func, irq_addr, irq_data);
        end
        tick;
        checks++;
        if ({irq_valid, req_ready} !== {1'b0, 4'hF}) begin
            failures++;
            $display("FAIL rr_end got valid=%b ready=%h want 0/f", irq_valid, req_ready);
        end
    endtask

    task automatic test_reset_mid_issue;
        do_reset;
        for (int k = 0; k < 3; k++) set_req(k, 64'hFEE0_5000 + 64'(k), 32'h50 + 32'(k));
        req_valid = 4'b0111;
        tick;
        req_valid = '0;
        tick;
        checks++;
        if ({irq_valid, irq_func, req_ready} !== {1'b1, 4'd0, 4'b1000}) begin
            failures++;
            $display("FAIL mid_issue got valid=%b func=%0d ready=%b want 1/0/1000", irq_valid, irq_func, req_ready);
        end
        rst = 1'b0;
        tick;
        checks++;
        if (irq_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got valid=%b want 0", irq_valid);
        end
        rst = 1'b1;
        irq_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick;
            checks++;
            if ({irq_valid, req_ready} !== {1'b0, 4'hF}) begin
                failures++;
                $display("FAIL mid_quiet%0d got valid=%b ready=%h want 0/f", c, irq_valid, req_ready);
            end
        end
    endtask

`ifdef IRQ_ARB_TIMEOUT_EN
    task automatic test_timeout;
        do_reset;
        set_req(0, 64'hFEE0_7000, 32'h70);
        set_req(2, 64'hFEE0_7200, 32'h72);
        req_valid = 4'b0101;
        tick;
        req_valid = '0;
        for (int c = 0; c < TO; c++) begin
            tick;
            checks++;
            if ({irq_valid, irq_func, timeout_pulse} !== {1'b1, 4'd0, 1'b0}) begin
                failures++;
                $display("FAIL to_wait%0d got valid=%b func=%0d tp=%b want 1/0/0", c, irq_valid, irq_func, timeout_pulse);
            end
        end
        tick;
        checks++;
        if ({irq_valid, timeout_pulse, timeout_id, req_ready} !== {1'b0, 1'b1, 2'd0, 4'b1011}) begin
            failures++;
            $display("FAIL to_abort got valid=%b tp=%b tid=%0d ready=%b want 0/1/0/1011",
                     irq_valid, timeout_pulse, timeout_id, req_ready);
        end
        tick;
        checks++;
        if ({irq_valid, irq_func, irq_data, timeout_pulse} !== {1'b1, 4'd2, 32'h72, 1'b0}) begin
            failures++;
            $display("FAIL to_next got valid=%b func=%0d data=%h tp=%b want 1/2/72/0",
                     irq_valid, irq_func, irq_data, timeout_pulse);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_fairness;
        test_backpressure;
        test_rerequest;
        test_reset_mid_issue;
`ifdef IRQ_ARB_TIMEOUT_EN
        test_timeout;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/irq_arbiter.md
IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of interrupt requesters (fixed 4; irq_func index width 2 bits).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, cycles irq_valid may wait for irq_ready before abort (used only with IRQ_ARB_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid  input  4  per-requester interrupt request.
REQ-006 SHALL have port req_addr  input  4x64  per-requester MSI-X address.
REQ-007 SHALL have port req_data  input  4x32  per-requester MSI-X data.
REQ-008 SHALL have port req_ready  output  4  per-requester accept.
REQ-009 SHALL have port irq_valid  output  1  request to irq_proc.
REQ-010 SHALL have port irq_func  output  4  granted requester index, zero-extended.
REQ-011 SHALL have port irq_addr  output  64  granted address.
REQ-012 SHALL have port irq_data  output  32  granted data.
REQ-013 SHALL have port irq_ready  input  1  irq_proc accept.
REQ-014 SHALL have port timeout_pulse  output  1  one-cycle abort indication.
REQ-015 SHALL have port timeout_id  output  2  index of aborted requester.

Function
REQ-016 Per requester: one pending slot; req_ready[i] = NOT pending[i]; on req_valid[i] & req_ready[i], capture addr/data and set pending[i] next cycle.
REQ-017 FSM states IDLE, ISSUE; IDLE with any pending -> ISSUE, registering grant g = first pending index at or after rr_ptr, cyclic.
REQ-018 In ISSUE, irq_valid=1; irq_func/irq_addr/irq_data SHALL hold stable until handshake or abort.
REQ-019 On irq_valid & irq_ready: clear pending[g], rr_ptr <= (g+1) mod 4, irq_valid <= 0, state -> IDLE; minimum one idle cycle between grants.
REQ-020 Latency: request accepted in cycle N -> irq_valid asserted in cycle N+2 when arbiter idle.
REQ-021 Granted slot SHALL NOT accept a new request until cleared; new request for that index accepted the cycle after clear.
REQ-022 Requests arriving while ISSUE SHALL only be latched, never alter current grant.
REQ-023 rr_ptr wraps 3 -> 0; all four pending with rr_ptr=0 -> grant order 0,1,2,3.
REQ-024 Output data from pending slot register, never combinationally from req_* inputs.

Reset
REQ-025 While rst=0 at a clk edge: pending=0, rr_ptr=0, state=IDLE, irq_valid=0, irq_func=0, irq_addr=0, irq_data=0, timeout_pulse=0, timeout_id=0, timeout counter=0; req_ready=4'hF from first cycle after reset release.
REQ-026 Reset mid-ISSUE SHALL drop the in-flight request and all pending slots without handshake.

Configuration
REQ-027 Macro IRQ_ARB_TIMEOUT_EN defined: counter clears on ISSUE entry, increments each ISSUE cycle without irq_ready; on reaching TIMEOUT_CYCLES: clear pending[g], advance rr_ptr as REQ-019, irq_valid <= 0, timeout_pulse=1 for one cycle, timeout_id=g.
REQ-028 Macro undefined: no counter; ISSUE waits indefinitely; timeout_pulse and timeout_id tied 0.

Verification
REQ-029 Single: req_valid=4'b0100, addr=64'h0000_0000_FEE0_0000, data=32'h0000_0042, irq_ready=1 -> irq_valid at N+2, irq_func=2, addr/data match, req_ready[2] high again one cycle after handshake.
REQ-030 Fairness: all four requesters pending simultaneously, irq_ready=1 -> grants 0,1,2,3, each irq_valid pulse separated by idle cycle.
REQ-031 Backpressure: requester 1 granted, irq_ready=0 for 20 cycles then 1 -> irq_addr/irq_data/irq_func constant for all 21 cycles, single handshake.
REQ-032 Re-request: requester 3 re-asserts req_valid during its own grant -> req_ready[3]=0 until handshake, second request issued after requester 0 if 0 pending (rr_ptr wrapped to 0).
REQ-033 Timeout (IRQ_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): irq_ready held 0 -> after 16 ISSUE cycles timeout_pulse=1 one cycle, timeout_id=granted index, next pending requester granted.
REQ-034 Reset: rst=0 while irq_valid=1 with 3 pending -> next cycle irq_valid=0, req_ready=4'hF after release, no further irq_valid without new requests.
